// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 8N1 UART receiver running on the 16x oversampled transmit clock.
//
// The pin is synchronized, start bits are qualified by a mid-bit majority vote,
// each data bit and the stop bit are majority-voted at mid-period, and each good
// byte is presented with a one-cycle strobe.
//
// Ports:
//   tx_clk          in   oversampling clock (OVERSAMPLE x baud), shared with the TX side
//   reset           in   asynchronous, active-high
//   uart_rx         in   raw serial line, idle high, asynchronous to tx_clk
//   uart_data       out  last correctly framed byte, LSB received first
//   uart_data_valid out  one-cycle pulse, uart_data is new in the same cycle
//   uart_frame_err  out  one-cycle pulse when the stop bit votes low
//   uart_busy       out  high whenever the receiver is not idle
module uart_rx_os16 #(
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       tx_clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] uart_data,
    output logic       uart_data_valid,
    output logic       uart_frame_err,
    output logic       uart_busy
);

    localparam int unsigned CntW = $clog2(OVERSAMPLE);

    localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);
    localparam logic [CntW-1:0] VoteLo  = CntW'(OVERSAMPLE / 2 - 1);
    localparam logic [CntW-1:0] VoteMid = CntW'(OVERSAMPLE / 2);
    localparam logic [CntW-1:0] VoteHi  = CntW'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StStop     = 3'd3;
    localparam logic [2:0] StWaitHigh = 3'd4;

    // Input synchronizer; resets to the idle (high) line level.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], uart_rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bidx_q, bidx_d;
    logic [7:0]      shift_q, shift_d;
    logic [2:0]      vote_q, vote_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            busy_q, busy_d;

    logic            cnt_wrap;
    logic            decide;
    logic            maj;

    assign cnt_wrap = (cnt_q == CntLast);
    assign decide   = (cnt_q == VoteHi);
    // The third vote is the live sample, so the decision lands on the last vote sample.
    assign maj      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_wrap ? '0 : cnt_q + CntW'(1);
        bidx_d  = bidx_q;
        shift_d = shift_q;
        vote_d  = vote_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        if (cnt_q == VoteLo) begin
            vote_d[0] = rx_s;
        end else if (cnt_q == VoteMid) begin
            vote_d[1] = rx_s;
        end else if (cnt_q == VoteHi) begin
            vote_d[2] = rx_s;
        end

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    // This cycle is sample 0 of the start bit.
                    state_d = StStart;
                    cnt_d   = CntW'(1);
                end
            end
            StStart: begin
                if (decide && maj) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_wrap) begin
                    state_d = StData;
                    bidx_d  = '0;
                end
            end
            StData: begin
                if (decide) begin
                    shift_d[bidx_q] = maj;
                end
                if (cnt_wrap) begin
                    if (bidx_q == 3'd7) begin
                        state_d = StStop;
                        bidx_d  = '0;
                    end else begin
                        bidx_d = bidx_q + 3'd1;
                    end
                end
            end
            StStop: begin
                if (decide) begin
                    cnt_d = '0;
                    if (maj) begin
                        // Returning early lets a following start bit be caught mid-stop.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                // A held break reports once, then waits for the line to recover.
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge tx_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shift_q <= '0;
            vote_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shift_q <= shift_d;
            vote_q  <= vote_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    assign uart_data       = data_q;
    assign uart_data_valid = valid_q;
    assign uart_frame_err  = ferr_q;
    assign uart_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_os16.sv
// Testbench for uart_rx_os16: builds serial waveforms sample by sample, drives them,
// and compares the recorded output pulses against a frame-level reference model.
module tb_uart_rx_os16;

    logic       tx_clk;
    logic       reset;
    logic       uart_rx;
    logic [7:0] uart_data;
    logic       uart_data_valid;
    logic       uart_frame_err;
    logic       uart_busy;

    uart_rx_os16 #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .tx_clk         (tx_clk),
        .reset          (reset),
        .uart_rx        (uart_rx),
        .uart_data      (uart_data),
        .uart_data_valid(uart_data_valid),
        .uart_frame_err (uart_frame_err),
        .uart_busy      (uart_busy)
    );

    initial tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    int unsigned errs   = 0;
    int unsigned checks = 0;

    int          cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    // Output monitor: records pulses and their cycle numbers.
    logic [7:0] vq[$];
    int         vc[$];
    int         fc[$];
    int         both_cnt   = 0;
    int         consec_cnt = 0;
    int         busy_cnt   = 0;
    logic       prev_pulse = 1'b0;

    always @(posedge tx_clk) begin
        #1;
        if (uart_data_valid) begin
            vq.push_back(uart_data);
            vc.push_back(cyc);
        end
        if (uart_frame_err) fc.push_back(cyc);
        if (uart_data_valid && uart_frame_err) both_cnt++;
        if ((uart_data_valid || uart_frame_err) && prev_pulse) consec_cnt++;
        prev_pulse = uart_data_valid | uart_frame_err;
        if (uart_busy) busy_cnt++;
    end

    // Waveform: one entry per tx_clk cycle of line level.
    logic wave[$];
    int   start_cyc;
    logic [7:0] last_good = 8'h00;

    // Append a frame; bit boundaries fall at multiples of p100/100 cycles.
    task automatic add_frame(input logic [7:0] b, input int p100, input int stop_cyc,
                             input logic stop_val);
        int   e;
        int   target;
        logic lvl;
        e = 0;
        for (int i = 0; i < 9; i++) begin
            lvl    = (i == 0) ? 1'b0 : b[i-1];
            target = ((i + 1) * p100) / 100;
            while (e < target) begin
                wave.push_back(lvl);
                e++;
            end
        end
        for (int i = 0; i < stop_cyc; i++) wave.push_back(stop_val);
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) wave.push_back(1'b1);
    endtask

    // Reference decode at nominal rate: majority of the three mid-bit samples.
    function automatic logic [7:0] model_decode(input int base);
        logic [7:0] r;
        int         c;
        int         s;
        for (int k = 0; k < 8; k++) begin
            c    = base + 16 * (k + 1) + 8;
            s    = int'(wave[c-1]) + int'(wave[c]) + int'(wave[c+1]);
            r[k] = (s >= 2);
        end
        return r;
    endfunction

    task automatic clear_mon();
        vq.delete();
        vc.delete();
        fc.delete();
        busy_cnt = 0;
    endtask

    // Drive the first n entries of the waveform (all if n < 0), then idle high.
    task automatic drive_wave(input int n);
        int len;
        len       = (n < 0) ? wave.size() : n;
        start_cyc = cyc;
        for (int i = 0; i < len; i++) begin
            uart_rx = wave[i];
            @(posedge tx_clk);
            #1;
        end
        uart_rx = 1'b1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge tx_clk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        uart_rx = 1'b1;
        idle_cycles(3);
        checks++; if (uart_data !== 8'h00) begin errs++; $display("FAIL reset_data: got %h want 00", uart_data); end
        checks++; if (uart_data_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b want 0", uart_data_valid); end
        checks++; if (uart_frame_err !== 1'b0) begin errs++; $display("FAIL reset_ferr: got %b want 0", uart_frame_err); end
        checks++; if (uart_busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", uart_busy); end
        reset = 1'b0;
        idle_cycles(10);
    endtask

    task automatic test_nominal();
        clear_mon();
        wave.delete();
        add_frame(8'h55, 1600, 16, 1'b1);
        add_idle(20);
        drive_wave(-1);
        last_good = 8'h55;
        checks++; if (vq.size() !== 1) begin errs++; $display("FAIL nominal_count: got %0d want 1", vq.size()); end
        if (vq.size() == 1) begin
            checks++; if (vq[0] !== 8'h55) begin errs++; $display("FAIL nominal_data: got %h want 55", vq[0]); end
            checks++; if (vc[0] !== start_cyc + 156) begin errs++; $display("FAIL nominal_latency: got %0d want %0d", vc[0], start_cyc + 156); end
        end
        checks++; if (fc.size() !== 0) begin errs++; $display("FAIL nominal_ferr: got %0d want 0", fc.size()); end
        checks++; if (uart_busy !== 1'b0) begin errs++; $display("FAIL nominal_busy: got %b want 0", uart_busy); end
        checks++; if (uart_data !== 8'h55) begin errs++; $display("FAIL nominal_hold: got %h want 55", uart_data); end
    endtask

    task automatic test_frame_err();
        clear_mon();
        wave.delete();
        add_frame(8'hA5, 1600, 16 + 40 * 16, 1'b0);
        add_idle(30);
        drive_wave(-1);
        checks++; if (fc.size() !== 1) begin errs++; $display("FAIL ferr_count: got %0d want 1", fc.size()); end
        if (fc.size() == 1) begin
            checks++; if (fc[0] !== start_cyc + 156) begin errs++; $display("FAIL ferr_latency: got %0d want %0d", fc[0], start_cyc + 156); end
        end
        checks++; if (vq.size() !== 0) begin errs++; $display("FAIL ferr_valid: got %0d want 0", vq.size()); end
        checks++; if (uart_data !== last_good) begin errs++; $display("FAIL ferr_hold: got %h want %h", uart_data, last_good); end
        clear_mon();
        wave.delete();
        add_frame(8'h3C, 1600, 16, 1'b1);
        add_idle(20);
        drive_wave(-1);
        last_good = 8'h3C;
        checks++; if (vq.size() !== 1 || vq[0] !== 8'h3C) begin errs++; $display("FAIL ferr_recover: got n=%0d want one 3c", vq.size()); end
        checks++; if (fc.size() !== 0) begin errs++; $display("FAIL ferr_recover_err: got %0d want 0", fc.size()); end
    endtask

    task automatic test_glitch();
        clear_mon();
        wave.delete();
        for (int i = 0; i < 4; i++) wave.push_back(1'b0);
        add_idle(30);
        drive_wave(-1);
        checks++; if (busy_cnt !== 9) begin errs++; $display("FAIL glitch_busy: got %0d want 9", busy_cnt); end
        checks++; if (vq.size() !== 0 || fc.size() !== 0) begin errs++; $display("FAIL glitch_pulse: got v=%0d f=%0d want 0", vq.size(), fc.size()); end
        clear_mon();
        wave.delete();
        add_frame(8'hA3, 1600, 16, 1'b1);
        add_idle(20);
        drive_wave(-1);
        last_good = 8'hA3;
        checks++; if (vq.size() !== 1 || vq[0] !== 8'hA3) begin errs++; $display("FAIL glitch_then_a3: got n=%0d want one a3", vq.size()); end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        wave.delete();
        add_frame(8'h00, 1648, 10, 1'b1);
        add_frame(8'hFF, 1552, 10, 1'b1);
        add_idle(40);
        drive_wave(-1);
        last_good = 8'hFF;
        checks++; if (vq.size() !== 2) begin errs++; $display("FAIL b2b_count: got %0d want 2", vq.size()); end
        if (vq.size() == 2) begin
            checks++; if (vq[0] !== 8'h00) begin errs++; $display("FAIL b2b_first: got %h want 00", vq[0]); end
            checks++; if (vq[1] !== 8'hFF) begin errs++; $display("FAIL b2b_second: got %h want ff", vq[1]); end
        end
        checks++; if (fc.size() !== 0) begin errs++; $display("FAIL b2b_ferr: got %0d want 0", fc.size()); end
    endtask

    task automatic test_vote();
        clear_mon();
        wave.delete();
        add_frame(8'h0F, 1600, 16, 1'b1);
        for (int k = 0; k < 8; k++) wave[16 * (k + 1) + 8] = ~wave[16 * (k + 1) + 8];
        add_idle(20);
        drive_wave(-1);
        checks++; if (vq.size() !== 1 || vq[0] !== 8'h0F) begin errs++; $display("FAIL vote_single: got n=%0d want one 0f", vq.size()); end
        clear_mon();
        wave.delete();
        add_frame(8'h0F, 1600, 16, 1'b1);
        wave[16 + 7] = 1'b0;
        wave[16 + 8] = 1'b0;
        add_idle(20);
        drive_wave(-1);
        last_good = 8'h0E;
        checks++; if (vq.size() !== 1 || vq[0] !== 8'h0E) begin errs++; $display("FAIL vote_double: got n=%0d want one 0e", vq.size()); end
    endtask

    task automatic test_random();
        int         bases[$];
        logic [7:0] exp_b[$];
        int         base;
        int         k;
        int         s;
        clear_mon();
        wave.delete();
        for (int f = 0; f < 6; f++) begin
            add_idle($urandom_range(0, 5));
            base = wave.size();
            add_frame(8'($urandom), 1600, $urandom_range(10, 20), 1'b1);
            // Corrupt one or two vote samples of a random data bit.
            k = $urandom_range(0, 7);
            s = $urandom_range(7, 9);
            wave[base + 16 * (k + 1) + s] = ~wave[base + 16 * (k + 1) + s];
            if ($urandom_range(0, 1) == 1) begin
                s = (s == 9) ? 7 : s + 1;
                wave[base + 16 * (k + 1) + s] = ~wave[base + 16 * (k + 1) + s];
            end
            bases.push_back(base);
            exp_b.push_back(model_decode(base));
        end
        add_idle(30);
        drive_wave(-1);
        last_good = exp_b[5];
        checks++; if (vq.size() !== 6) begin errs++; $display("FAIL rand_count: got %0d want 6", vq.size()); end
        if (vq.size() == 6) begin
            for (int f = 0; f < 6; f++) begin
                checks++;
                if (vq[f] !== exp_b[f] || vc[f] !== start_cyc + bases[f] + 156) begin
                    errs++;
                    $display("FAIL rand_frame%0d: got %h@%0d want %h@%0d", f, vq[f], vc[f],
                             exp_b[f], start_cyc + bases[f] + 156);
                end
            end
        end
        checks++; if (fc.size() !== 0) begin errs++; $display("FAIL rand_ferr: got %0d want 0", fc.size()); end
    endtask

    task automatic test_reset_mid();
        clear_mon();
        wave.delete();
        add_frame(8'($urandom), 1600, 16, 1'b1);
        drive_wave(86);
        checks++; if (uart_busy !== 1'b1) begin errs++; $display("FAIL rmid_busy_before: got %b want 1", uart_busy); end
        #3;
        reset   = 1'b1;
        uart_rx = 1'b1;
        #1;
        checks++; if (uart_busy !== 1'b0) begin errs++; $display("FAIL rmid_busy: got %b want 0", uart_busy); end
        checks++; if (uart_data !== 8'h00) begin errs++; $display("FAIL rmid_data: got %h want 00", uart_data); end
        checks++; if (uart_data_valid !== 1'b0 || uart_frame_err !== 1'b0) begin errs++; $display("FAIL rmid_pulse: got v=%b f=%b want 0", uart_data_valid, uart_frame_err); end
        @(posedge tx_clk);
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(100);
        clear_mon();
        wave.delete();
        add_frame(8'h81, 1600, 16, 1'b1);
        add_idle(20);
        drive_wave(-1);
        last_good = 8'h81;
        checks++; if (vq.size() !== 1 || vq[0] !== 8'h81) begin errs++; $display("FAIL rmid_81: got n=%0d want one 81", vq.size()); end
        checks++; if (fc.size() !== 0) begin errs++; $display("FAIL rmid_ferr: got %0d want 0", fc.size()); end
        checks++; if (uart_data !== last_good) begin errs++; $display("FAIL rmid_hold: got %h want %h", uart_data, last_good); end
    endtask

    task automatic test_pulse_rules();
        checks++; if (both_cnt !== 0) begin errs++; $display("FAIL pulse_exclusive: got %0d want 0", both_cnt); end
        checks++; if (consec_cnt !== 0) begin errs++; $display("FAIL pulse_single: got %0d want 0", consec_cnt); end
    endtask

    initial begin
        reset   = 1'b1;
        uart_rx = 1'b1;
        test_reset();
        test_nominal();
        test_frame_err();
        test_glitch();
        test_back_to_back();
        test_vote();
        test_random();
        test_reset_mid();
        test_pulse_rules();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
